// File: rtl/char_pkg.sv
// Shared types and constants for the character buffer: cell layout, palette, clear FSM states.
package char_pkg;

    localparam int H_CHARS_DEF = 80;
    localparam int V_CHARS_DEF = 60;
    localparam int ADDR_W      = 13;

    typedef struct packed {
        logic [6:0] ch;
        logic [2:0] fg;
        logic [2:0] bg;
    } cell_t;

    localparam logic [11:0] PALETTE [8] = '{
        12'h000, 12'hF00, 12'h0F0, 12'hFF0,
        12'h00F, 12'hF0F, 12'h0FF, 12'hFFF
    };

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

endpackage

// File: rtl/char_buffer_font_rom.sv
// 8x8 glyph ROM: returns one glyph row, MSB = leftmost pixel.
module font_rom (
    input  logic [6:0] code,
    input  logic [2:0] row,
    output logic [7:0] row_bits
);
    localparam logic [63:0] BOX = 64'hFF81_8181_8181_81FF;

    logic [6:0]  up;
    logic [63:0] glyph;

    // Lowercase shares the uppercase glyphs; printable codes without a glyph show a box.
    assign up = (code >= 7'h61 && code <= 7'h7A) ? code - 7'h20 : code;

    always_comb begin
        glyph = 64'h0;
        if (up > 7'h20 && up != 7'h7F) begin
            case (up)
                7'h30: glyph = 64'h3C66_6E76_6666_3C00;
                7'h31: glyph = 64'h1838_1818_1818_7E00;
                7'h32: glyph = 64'h3C66_060C_3060_7E00;
                7'h33: glyph = 64'h3C66_061C_0666_3C00;
                7'h34: glyph = 64'h0C1C_3C6C_7E0C_0C00;
                7'h35: glyph = 64'h7E60_7C06_0666_3C00;
                7'h36: glyph = 64'h3C66_607C_6666_3C00;
                7'h37: glyph = 64'h7E66_0C18_1818_1800;
                7'h38: glyph = 64'h3C66_663C_6666_3C00;
                7'h39: glyph = 64'h3C66_663E_0666_3C00;
                7'h41: glyph = 64'h183C_6666_7E66_6600;
                7'h42: glyph = 64'h7C66_667C_6666_7C00;
                7'h43: glyph = 64'h3C66_6060_6066_3C00;
                7'h44: glyph = 64'h786C_6666_666C_7800;
                7'h45: glyph = 64'h7E60_6078_6060_7E00;
                7'h46: glyph = 64'h7E60_6078_6060_6000;
                7'h47: glyph = 64'h3C66_606E_6666_3C00;
                7'h48: glyph = 64'h6666_667E_6666_6600;
                7'h49: glyph = 64'h3C18_1818_1818_3C00;
                7'h4A: glyph = 64'h1E0C_0C0C_0C6C_3800;
                7'h4B: glyph = 64'h666C_7870_786C_6600;
                7'h4C: glyph = 64'h6060_6060_6060_7E00;
                7'h4D: glyph = 64'h6377_7F6B_6363_6300;
                7'h4E: glyph = 64'h6676_7E7E_6E66_6600;
                7'h4F: glyph = 64'h3C66_6666_6666_3C00;
                7'h50: glyph = 64'h7C66_667C_6060_6000;
                7'h51: glyph = 64'h3C66_6666_663C_0E00;
                7'h52: glyph = 64'h7C66_667C_786C_6600;
                7'h53: glyph = 64'h3C66_603C_0666_3C00;
                7'h54: glyph = 64'h7E18_1818_1818_1800;
                7'h55: glyph = 64'h6666_6666_6666_3C00;
                7'h56: glyph = 64'h6666_6666_663C_1800;
                7'h57: glyph = 64'h6363_636B_7F77_6300;
                7'h58: glyph = 64'h6666_3C18_3C66_6600;
                7'h59: glyph = 64'h6666_663C_1818_1800;
                7'h5A: glyph = 64'h7E06_0C18_3060_7E00;
                default: glyph = BOX;
            endcase
        end
    end

    assign row_bits = glyph[{~row, 3'b000} +: 8];

endmodule

// File: rtl/char_buffer.sv
// 80x60 text buffer with glyph renderer for the VGA driver, producer write port and clear engine.
module char_buffer
    import char_pkg::*;
#(
    parameter int         H_CHARS    = H_CHARS_DEF,
    parameter int         V_CHARS    = V_CHARS_DEF,
    parameter logic [6:0] CLEAR_CHAR = 7'h20,
    parameter logic [2:0] CLEAR_FG   = 3'd7,
    parameter logic [2:0] CLEAR_BG   = 3'd0
) (
    input  logic       clk_25M,
    input  logic       rst,
    input  logic [6:0] read_hchar,
    input  logic [5:0] read_vchar,
    input  logic [2:0] read_hoffset,
    input  logic [2:0] read_voffset,
    output logic [3:0] pixel_red,
    output logic [3:0] pixel_green,
    output logic [3:0] pixel_blue,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_hchar,
    input  logic [5:0] wr_vchar,
    input  logic [6:0] wr_char,
    input  logic [2:0] wr_fg,
    input  logic [2:0] wr_bg,
    output logic       wr_err,
    input  logic       clear_req,
    output logic       clear_busy
);
    localparam int                N_CELLS    = H_CHARS * V_CHARS;
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(N_CELLS - 1);
    localparam cell_t             CLEAR_CELL = '{ch: CLEAR_CHAR, fg: CLEAR_FG, bg: CLEAR_BG};

    cell_t              mem [N_CELLS];
    state_t             state;
    logic [ADDR_W-1:0]  clr_cnt;

    logic               rd_in_range, wr_in_range, wr_fire, glyph_bit;
    logic [ADDR_W-1:0]  rd_addr, wr_addr;
    cell_t              rd_cell;
    logic [7:0]         font_bits;
    logic [11:0]        rgb_next, pixel_rgb;

    assign rd_in_range = (int'(read_hchar) < H_CHARS) && (int'(read_vchar) < V_CHARS);
    assign rd_addr     = ADDR_W'(int'(read_vchar) * H_CHARS + int'(read_hchar));
    // Asynchronous read before the write edge gives read-first collision behaviour.
    assign rd_cell     = rd_in_range ? mem[rd_addr] : '0;

    font_rom u_font (
        .code     (rd_cell.ch),
        .row      (read_voffset),
        .row_bits (font_bits)
    );

    assign glyph_bit = font_bits[~read_hoffset];
    assign rgb_next  = !rd_in_range ? 12'h000
                     : (glyph_bit ? PALETTE[rd_cell.fg] : PALETTE[rd_cell.bg]);

    always_ff @(posedge clk_25M) begin
        if (rst) pixel_rgb <= 12'h000;
        else     pixel_rgb <= rgb_next;
    end

    assign pixel_red   = pixel_rgb[11:8];
    assign pixel_green = pixel_rgb[7:4];
    assign pixel_blue  = pixel_rgb[3:0];

    assign wr_ready    = ~clear_busy;
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = (int'(wr_hchar) < H_CHARS) && (int'(wr_vchar) < V_CHARS);
    assign wr_addr     = ADDR_W'(int'(wr_vchar) * H_CHARS + int'(wr_hchar));

    always_ff @(posedge clk_25M) begin
        if (state == CLEAR)
            mem[clr_cnt] <= CLEAR_CELL;
        else if (wr_fire && wr_in_range)
            mem[wr_addr] <= '{ch: wr_char, fg: wr_fg, bg: wr_bg};
    end

    always_ff @(posedge clk_25M) begin
        if (rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
            wr_err     <= 1'b0;
        end else begin
            wr_err <= wr_fire & ~wr_in_range;
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST_CELL) begin
                        state      <= IDLE;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_char_buffer.sv
// Scoreboard bench for char_buffer: reads push expected RGB, a monitor checks it one cycle later.
module tb_char_buffer;

    logic       clk_25M = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] read_hchar = '0;
    logic [5:0] read_vchar = '0;
    logic [2:0] read_hoffset = '0, read_voffset = '0;
    logic [3:0] pixel_red, pixel_green, pixel_blue;
    logic       wr_valid = 1'b0, wr_ready;
    logic [6:0] wr_hchar = '0;
    logic [5:0] wr_vchar = '0;
    logic [6:0] wr_char = '0;
    logic [2:0] wr_fg = '0, wr_bg = '0;
    logic       wr_err, clear_req = 1'b0, clear_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] rgb;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   read_id = 0;

    logic [7:0] a_rows [8] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};

    char_buffer dut (
        .clk_25M      (clk_25M),
        .rst          (rst),
        .read_hchar   (read_hchar),
        .read_vchar   (read_vchar),
        .read_hoffset (read_hoffset),
        .read_voffset (read_voffset),
        .pixel_red    (pixel_red),
        .pixel_green  (pixel_green),
        .pixel_blue   (pixel_blue),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_hchar     (wr_hchar),
        .wr_vchar     (wr_vchar),
        .wr_char      (wr_char),
        .wr_fg        (wr_fg),
        .wr_bg        (wr_bg),
        .wr_err       (wr_err),
        .clear_req    (clear_req),
        .clear_busy   (clear_busy)
    );

    always #20 clk_25M = ~clk_25M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called right after a negedge; the DUT samples the request at the next posedge.
    task automatic issue_read(input int h, input int v, input int ho, input int vo,
                              input logic [11:0] rgb);
        read_hchar   = 7'(h);
        read_vchar   = 6'(v);
        read_hoffset = 3'(ho);
        read_voffset = 3'(vo);
        exp_q.push_back('{rgb: rgb, id: read_id});
        read_id++;
    endtask

    task automatic do_write(input int h, input int v, input logic [6:0] c,
                            input logic [2:0] fg, input logic [2:0] bg);
        check("wr_ready_before_write", wr_ready, 1);
        wr_hchar = 7'(h);
        wr_vchar = 6'(v);
        wr_char  = c;
        wr_fg    = fg;
        wr_bg    = bg;
        wr_valid = 1'b1;
        @(negedge clk_25M);
        wr_valid = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int cnt = 0;
        int bad_ready = 0;
        while (clear_busy === 1'b1 && cnt < 6000) begin
            if (wr_ready !== 1'b0) bad_ready++;
            cnt++;
            @(negedge clk_25M);
        end
        check({name, "_busy_cycles"}, cnt, 4800);
        check({name, "_ready_low_while_busy"}, bad_ready, 0);
        check({name, "_ready_after"}, wr_ready, 1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_25M);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                #1;
                check($sformatf("read%0d_rgb", e.id), {pixel_red, pixel_green, pixel_blue}, e.rgb);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_25M);
        check("rst_busy", clear_busy, 1);
        check("rst_ready", wr_ready, 0);
        check("rst_err", wr_err, 0);
        check("rst_pixel", {pixel_red, pixel_green, pixel_blue}, 0);
        rst = 1'b0;
        count_busy("init");

        issue_read(0, 0, 0, 0, 12'h000);
        @(negedge clk_25M);
        issue_read(0, 0, 3, 4, 12'h000);
        @(negedge clk_25M);

        do_write(5, 3, 7'h41, 3'd1, 3'd4);
        check("a_write_err", wr_err, 0);
        for (int vo = 0; vo < 8; vo++) begin
            for (int ho = 0; ho < 8; ho++) begin
                issue_read(5, 3, ho, vo, a_rows[vo][7 - ho] ? 12'hF00 : 12'h00F);
                @(negedge clk_25M);
            end
        end

        do_write(80, 0, 7'h41, 3'd2, 3'd6);
        check("err_h80_pulse", wr_err, 1);
        @(negedge clk_25M);
        check("err_h80_clear", wr_err, 0);
        do_write(0, 60, 7'h41, 3'd2, 3'd6);
        check("err_v60_pulse", wr_err, 1);
        @(negedge clk_25M);
        check("err_v60_clear", wr_err, 0);
        issue_read(0, 1, 3, 1, 12'h000);
        @(negedge clk_25M);
        issue_read(0, 1, 0, 0, 12'h000);
        @(negedge clk_25M);
        issue_read(79, 59, 3, 1, 12'h000);
        @(negedge clk_25M);

        // Same-cycle write and read of (10,10): old blank cell, then the new 'H'.
        check("coll_ready", wr_ready, 1);
        wr_hchar = 7'd10; wr_vchar = 6'd10; wr_char = 7'h48; wr_fg = 3'd3; wr_bg = 3'd5;
        wr_valid = 1'b1;
        issue_read(10, 10, 1, 0, 12'h000);
        @(negedge clk_25M);
        wr_valid = 1'b0;
        issue_read(10, 10, 1, 0, 12'hFF0);
        @(negedge clk_25M);
        issue_read(10, 10, 0, 0, 12'hF0F);
        @(negedge clk_25M);

        issue_read(5, 3, 3, 0, 12'hF00);
        @(negedge clk_25M);
        issue_read(127, 63, 3, 0, 12'h000);
        @(negedge clk_25M);
        issue_read(85, 2, 3, 0, 12'h000);
        @(negedge clk_25M);

        clear_req = 1'b1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk_25M);
            clear_req = (cyc == 100);
            if (cyc == 1)   check("req_busy", clear_busy, 1);
            if (cyc == 100) issue_read(5, 3, 3, 0, 12'hF00);
            if (cyc == 200) check("req_ready_low", wr_ready, 0);
            if (cyc == 300) issue_read(5, 3, 3, 0, 12'h000);
            if (cyc == 2000) begin
                check("busy_before_rst", clear_busy, 1);
                rst = 1'b1;
            end
        end
        @(negedge clk_25M);
        check("midclear_rst_busy", clear_busy, 1);
        rst = 1'b0;
        count_busy("rst_restart");
        issue_read(10, 10, 1, 0, 12'h000);
        @(negedge clk_25M);

        repeat (3) @(negedge clk_25M);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_buffer.md
Name: char_buffer

Overview:
- Character store and glyph renderer directly upstream of the VGA driver: holds an 80x60 grid of character cells (ASCII code plus foreground/background colour indices).
- Answers the driver's per-pixel coordinate request with 12-bit RGB exactly one cycle later.
- Exposes a valid/ready write port for the text producer and a hardware clear engine that blanks the screen after reset or on request.

Parameters:
- H_CHARS, 80, character columns
- V_CHARS, 60, character rows
- CLEAR_CHAR, 7'h20, code written to every cell by the clear engine
- CLEAR_FG, 3'd7, foreground index written by clear
- CLEAR_BG, 3'd0, background index written by clear

Ports:
- clk_25M  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- read_hchar  in  7  column of requested pixel
- read_vchar  in  6  row of requested pixel
- read_hoffset  in  3  pixel column within glyph (0 = leftmost)
- read_voffset  in  3  pixel row within glyph (0 = top)
- pixel_red  out  4  red of pixel requested previous cycle
- pixel_green  out  4  green, same timing
- pixel_blue  out  4  blue, same timing
- wr_valid  in  1  write request
- wr_ready  out  1  buffer can accept a write this cycle
- wr_hchar  in  7  target column
- wr_vchar  in  6  target row
- wr_char  in  7  ASCII code
- wr_fg  in  3  foreground palette index
- wr_bg  in  3  background palette index
- wr_err  out  1  one-cycle pulse: accepted write was out of range and dropped
- clear_req  in  1  start a full-screen clear
- clear_busy  out  1  clear engine active

Behaviour:
- Storage: 4800 entries x 13 bits {char[6:0], fg[2:0], bg[2:0]}.
- Cell address = vchar*H_CHARS + hchar, 13-bit unsigned; no wrap.
- Read path:
  - Inputs are sampled combinationally into cell memory and font ROM.
  - One register stage drives pixel_*; latency is exactly 1 cycle and every cycle is a new request (no stall).
  - Glyph bit = font_row[7 - read_hoffset]. Bit 1 outputs palette[fg], bit 0 outputs palette[bg].
  - read_hchar >= H_CHARS or read_vchar >= V_CHARS outputs 12'h000.
- Read/write collision on the same cell in the same cycle: the read returns the old contents (read-first). The new value is visible from the next request onward.
- Write handshake:
  - A write transfers on wr_valid & wr_ready and commits at that clock edge.
  - wr_ready = ~clear_busy.
  - Out-of-range coordinates are dropped, and wr_err pulses high on the following cycle.
  - A write is never lost while wr_ready = 1.
- FSM, two states:
  - CLEAR: writes {CLEAR_CHAR, CLEAR_FG, CLEAR_BG} to the cell at clear counter, one cell per cycle from 0 to 4799. On reaching 4799 it moves to IDLE.
  - IDLE: accepts writes. clear_req = 1 moves to CLEAR with the counter at 0.
  - clear_req while already in CLEAR is ignored; it does not restart the sweep.
- Clear duration: exactly 4800 cycles. clear_busy falls on the cycle after cell 4799 is written.
- Reading continues during a clear and shows partially cleared contents.
- Reset:
  - Applies in any state, including mid-clear, and restarts a full clear.
  - Reset values: state = CLEAR, counter = 0, clear_busy = 1, wr_ready = 0, wr_err = 0, pixel_* = 0.
  - Memory contents are not reset directly; the clear sweep initialises them.
- Palette, 12-bit RGB: 0 black 000, 1 red F00, 2 green 0F0, 3 yellow FF0, 4 blue 00F, 5 magenta F0F, 6 cyan 0FF, 7 white FFF.

Decomposition:
- Package char_pkg holds:
  - H_CHARS/V_CHARS defaults
  - cell_t packed struct {char, fg, bg}
  - palette constant array
  - FSM state enum {CLEAR, IDLE}
- Sub-module font_rom: combinational, 7-bit code plus 3-bit row in, 8-bit row bitmap out (MSB = leftmost pixel). Codes 0x00-0x1F and 0x7F give an all-zero bitmap.

Test Plan:
- Reset, hold idle -> clear_busy = 1 and wr_ready = 0 for exactly 4800 cycles; afterwards reading cell (0,0) gives 12'h000 and pixel_* reflects bg = 0.
- After clear, write 'A' (0x41) fg=1 bg=4 at (5,3), then sweep offsets (0..7, 0..7) -> each output lags by 1 cycle; set glyph bits give F00, clear bits give 00F.
- Write at (80,0) and then (0,60) -> wr_err pulses once per write, and reading (79,59) still shows the clear pattern.
- Write to (10,10) while reading (10,10) in the same cycle -> that read returns the old data, the next read returns the new.
- clear_req in IDLE, reassert clear_req at cycle 100, then assert rst at cycle 2000 -> the reassertion is ignored, rst restarts the sweep, and busy falls 4800 cycles after the rst release.
- Read at (127,63) -> pixel_* = 0 one cycle later.
